serial_compare_scheduler: RTL

- Shares one MSB-first serial magnitude-compare datapath between N_REQ requesters.
- Each requester presents a parallel operand pair (a, b) over a valid/ready handshake.
- The block round-robin arbitrates, serializes the winning pair MSB-first through an internal sticky less/equal/greater FSM, and returns a tagged one-hot result over a valid/ready handshake.
- It sits between parallel producers and the shared bit-serial compare resource.

---
 rtl/serial_compare_scheduler.sv | 135 +++++++++++++
 1 files changed

// File: rtl/serial_compare_scheduler.sv
// Round-robin scheduler that shares one MSB-first bit-serial magnitude comparator
// between N_REQ requesters and returns a tagged one-hot less/equal/greater result.
module serial_compare_scheduler #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned W     = 8,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [ID_W-1:0]    res_id,
  output logic               res_less,
  output logic               res_eq,
  output logic               res_greater
);

  localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;
  typedef enum logic [1:0] {CmpEq, CmpLess, CmpGreater} cmp_e;

  state_e            r_state, w_state_d;
  cmp_e              r_cmp, w_cmp_d, w_cmp_bit;
  logic [W-1:0]      r_a, w_a_d;
  logic [W-1:0]      r_b, w_b_d;
  logic [ID_W-1:0]   r_id, w_id_d;
  logic [ID_W-1:0]   r_last_grant, w_last_grant_d;
  logic [CntW-1:0]   r_cnt, w_cnt_d;
  logic              w_found;
  logic [ID_W-1:0]   w_grant;

  // Search starts one past the last winner and wraps, giving round-robin fairness.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      int unsigned idx;
      idx = (32'(r_last_grant) + k) % N_REQ;
      if (!w_found && req_valid[idx]) begin
        w_found = 1'b1;
        w_grant = ID_W'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!rst && (r_state == StIdle) && w_found) begin
      req_ready[w_grant] = 1'b1;
    end
  end

  // Once a bit differs the verdict is sticky; later bits cannot override it.
  always_comb begin
    w_cmp_bit = r_cmp;
    if (r_cmp == CmpEq) begin
      if (r_a[W-1] && !r_b[W-1]) begin
        w_cmp_bit = CmpGreater;
      end else if (!r_a[W-1] && r_b[W-1]) begin
        w_cmp_bit = CmpLess;
      end
    end
  end

  always_comb begin
    w_state_d      = r_state;
    w_cmp_d        = r_cmp;
    w_a_d          = r_a;
    w_b_d          = r_b;
    w_id_d         = r_id;
    w_last_grant_d = r_last_grant;
    w_cnt_d        = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_found) begin
          w_a_d          = req_a[32'(w_grant)*W +: W];
          w_b_d          = req_b[32'(w_grant)*W +: W];
          w_id_d         = w_grant;
          w_last_grant_d = w_grant;
          w_cnt_d        = CntW'(W - 1);
          w_cmp_d        = CmpEq;
          w_state_d      = StShift;
        end
      end
      StShift: begin
        w_a_d   = r_a << 1;
        w_b_d   = r_b << 1;
        w_cmp_d = w_cmp_bit;
        if (r_cnt == '0) begin
          w_state_d = StDone;
        end else begin
          w_cnt_d = r_cnt - 1'b1;
        end
      end
      StDone: begin
        if (res_ready) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_cmp        <= CmpEq;
      r_a          <= '0;
      r_b          <= '0;
      r_id         <= '0;
      r_last_grant <= ID_W'(N_REQ - 1);
      r_cnt        <= '0;
    end else begin
      r_state      <= w_state_d;
      r_cmp        <= w_cmp_d;
      r_a          <= w_a_d;
      r_b          <= w_b_d;
      r_id         <= w_id_d;
      r_last_grant <= w_last_grant_d;
      r_cnt        <= w_cnt_d;
    end
  end

  assign res_valid   = (r_state == StDone);
  assign res_id      = res_valid ? r_id : '0;
  assign res_less    = res_valid && (r_cmp == CmpLess);
  assign res_eq      = res_valid && (r_cmp == CmpEq);
  assign res_greater = res_valid && (r_cmp == CmpGreater);

endmodule
